// File: rtl/direction_accumulator.sv
// rtl/direction_accumulator.sv - frame-level band/threshold-gated direction vector integrator
// Sums qualifying per-bin (x,y) with sticky saturation and hands each frame result through a valid/ready register.
module direction_accumulator #(
  parameter int          BIN_WIDTH     = 10,
  parameter int          BIN_LO        = 8,
  parameter int          BIN_HI        = 200,
  parameter logic [15:0] MAG_THRESHOLD = 16'h0100,
  parameter int          ACC_WIDTH     = 26
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [37:0]          vector_in,
  input  logic [15:0]          mag_in,
  input  logic [BIN_WIDTH-1:0] bin_in,
  input  logic                 valid_in,
  input  logic                 last_in,
  output logic [ACC_WIDTH-1:0] x_out,
  output logic [ACC_WIDTH-1:0] y_out,
  output logic [BIN_WIDTH:0]   count_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 overflow_out
);

  localparam logic [BIN_WIDTH-1:0] LO_BIN = BIN_LO[BIN_WIDTH-1:0];
  localparam logic [BIN_WIDTH-1:0] HI_BIN = BIN_HI[BIN_WIDTH-1:0];
  localparam logic [BIN_WIDTH:0]   CNT_MAX = '1;
  localparam logic signed [ACC_WIDTH:0] ACC_MAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] ACC_MIN = {2'b11, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                state_q, state_d;
  logic [ACC_WIDTH-1:0]  acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic                  sat_x_q, sat_x_d, sat_y_q, sat_y_d;
  logic [BIN_WIDTH:0]    acc_cnt_q, acc_cnt_d;
  logic [ACC_WIDTH-1:0]  x_q, y_q;
  logic [BIN_WIDTH:0]    cnt_q;
  logic                  overflow_q, overflow_d;
  logic                  load;
  logic                  qualify;
  logic                  frame_done;
  logic [ACC_WIDTH:0]    add_x, add_y;
  logic                  unused_bits;

  assign unused_bits = ^vector_in[37:32];
  assign qualify    = valid_in && (bin_in >= LO_BIN) && (bin_in <= HI_BIN) && (mag_in >= MAG_THRESHOLD);
  assign frame_done = valid_in && last_in;

  // Returns {saturated, clamped sum}; the extra bit of headroom catches the carry out.
  function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] acc,
                                                input logic [15:0] s);
    logic signed [ACC_WIDTH:0] sum;
    sum = {acc[ACC_WIDTH-1], acc} + {{(ACC_WIDTH-15){s[15]}}, s};
    if (sum > ACC_MAX) return {1'b1, ACC_MAX[ACC_WIDTH-1:0]};
    if (sum < ACC_MIN) return {1'b1, ACC_MIN[ACC_WIDTH-1:0]};
    return {1'b0, sum[ACC_WIDTH-1:0]};
  endfunction

  assign add_x = sat_add(acc_x_q, vector_in[15:0]);
  assign add_y = sat_add(acc_y_q, vector_in[31:16]);

  // Once an axis clips it is frozen for the rest of the frame.
  always_comb begin
    acc_x_d   = acc_x_q;
    acc_y_d   = acc_y_q;
    sat_x_d   = sat_x_q;
    sat_y_d   = sat_y_q;
    acc_cnt_d = acc_cnt_q;
    if (qualify) begin
      if (!sat_x_q) {sat_x_d, acc_x_d} = add_x;
      if (!sat_y_q) {sat_y_d, acc_y_d} = add_y;
      if (acc_cnt_q != CNT_MAX) acc_cnt_d = acc_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    overflow_d = overflow_q;
    case (state_q)
      EMPTY: begin
        if (frame_done) begin
          load    = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (frame_done) begin
          if (ready_in) load = 1'b1;
          else          overflow_d = 1'b1;
        end else if (ready_in) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= EMPTY;
      acc_x_q    <= '0;
      acc_y_q    <= '0;
      sat_x_q    <= 1'b0;
      sat_y_q    <= 1'b0;
      acc_cnt_q  <= '0;
      x_q        <= '0;
      y_q        <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
      if (frame_done) begin
        acc_x_q   <= '0;
        acc_y_q   <= '0;
        sat_x_q   <= 1'b0;
        sat_y_q   <= 1'b0;
        acc_cnt_q <= '0;
      end else begin
        acc_x_q   <= acc_x_d;
        acc_y_q   <= acc_y_d;
        sat_x_q   <= sat_x_d;
        sat_y_q   <= sat_y_d;
        acc_cnt_q <= acc_cnt_d;
      end
      if (load) begin
        x_q   <= acc_x_d;
        y_q   <= acc_y_d;
        cnt_q <= acc_cnt_d;
      end
    end
  end

  assign x_out        = x_q;
  assign y_out        = y_q;
  assign count_out    = cnt_q;
  assign valid_out    = (state_q == FULL);
  assign overflow_out = overflow_q;

endmodule

// File: tb/tb_direction_accumulator.sv
// tb/tb_direction_accumulator.sv - randomized and directed bench for direction_accumulator
// Reference model keeps frame sums as plain integers and the output register as valid/overflow flags.
module tb_direction_accumulator;

  localparam int AW    = 20;
  localparam int BW    = 10;
  localparam int MAXV  = (1 << (AW-1)) - 1;
  localparam int MINV  = -(1 << (AW-1));
  localparam int CMAX  = (1 << (BW+1)) - 1;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic [37:0]   vector_in = '0;
  logic [15:0]   mag_in = '0;
  logic [BW-1:0] bin_in = '0;
  logic          valid_in = 1'b0;
  logic          last_in = 1'b0;
  logic          ready_in = 1'b0;
  logic [AW-1:0] x_out, y_out;
  logic [BW:0]   count_out;
  logic          valid_out, overflow_out;

  int checks = 0;
  int errors = 0;

  int m_x, m_y, m_cnt;
  bit m_sx, m_sy;
  int e_x, e_y, e_cnt;
  bit e_v, e_ovf;

  direction_accumulator #(
    .BIN_WIDTH(BW), .BIN_LO(8), .BIN_HI(200), .MAG_THRESHOLD(16'h0100), .ACC_WIDTH(AW)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .vector_in(vector_in), .mag_in(mag_in),
    .bin_in(bin_in), .valid_in(valid_in), .last_in(last_in), .x_out(x_out),
    .y_out(y_out), .count_out(count_out), .valid_out(valid_out), .ready_in(ready_in),
    .overflow_out(overflow_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk_val({tag, ".x"},   32'(x_out),        32'(e_x[AW-1:0]));
    chk_val({tag, ".y"},   32'(y_out),        32'(e_y[AW-1:0]));
    chk_val({tag, ".cnt"}, 32'(count_out),    32'(e_cnt[BW:0]));
    chk_val({tag, ".vld"}, 32'(valid_out),    32'(e_v));
    chk_val({tag, ".ovf"}, 32'(overflow_out), 32'(e_ovf));
  endtask

  function automatic int clamp(input int v, output bit sat);
    sat = 1'b0;
    if (v > MAXV) begin sat = 1'b1; return MAXV; end
    if (v < MINV) begin sat = 1'b1; return MINV; end
    return v;
  endfunction

  task automatic model_clear_all();
    m_x = 0; m_y = 0; m_cnt = 0; m_sx = 0; m_sy = 0;
    e_x = 0; e_y = 0; e_cnt = 0; e_v = 0; e_ovf = 0;
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    last_in  = 1'b0;
    rst_in   = 1'b1;
    #1;
    model_clear_all();
    check_outputs("reset");
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
  endtask

  task automatic step(input int xi, input int yi, input int mag, input int bin,
                      input bit v, input bit l, input bit r, input string tag);
    bit q;
    bit s;
    vector_in = {6'($urandom), yi[15:0], xi[15:0]};
    mag_in    = mag[15:0];
    bin_in    = bin[BW-1:0];
    valid_in  = v;
    last_in   = l;
    ready_in  = r;
    q = v && bin >= 8 && bin <= 200 && mag >= 256;
    if (q) begin
      if (!m_sx) begin m_x = clamp(m_x + xi, s); m_sx = s; end
      if (!m_sy) begin m_y = clamp(m_y + yi, s); m_sy = s; end
      if (m_cnt < CMAX) m_cnt++;
    end
    if (v && l) begin
      if (!e_v || r) begin
        e_x = m_x; e_y = m_y; e_cnt = m_cnt; e_v = 1'b1;
      end else begin
        e_ovf = 1'b1;
      end
      m_x = 0; m_y = 0; m_cnt = 0; m_sx = 0; m_sy = 0;
    end else if (e_v && r) begin
      e_v = 1'b0;
    end
    @(posedge clk_in);
    #1;
    check_outputs(tag);
  endtask

  function automatic int rnd16();
    logic signed [15:0] t;
    t = 16'($urandom);
    return int'(t);
  endfunction

  initial begin
    model_clear_all();
    do_reset();

    step(16'h0200, 16'h0100, 'h200, 10, 1, 0, 1, "t1a");
    step(-512,     16'h0100, 'h200, 11, 1, 0, 1, "t1b");
    step(16'h0080, -256,     'h200, 12, 1, 1, 1, "t1c");
    chk_val("t1_x",   32'(x_out), 32'h080);
    chk_val("t1_y",   32'(y_out), 32'h100);
    chk_val("t1_cnt", 32'(count_out), 32'd3);
    chk_val("t1_vld", 32'(valid_out), 32'd1);
    step(0, 0, 0, 0, 0, 0, 1, "t1_idle");
    chk_val("t1_drop", 32'(valid_out), 32'd0);

    step(100, 100, 'h200, 7,   1, 0, 1, "t2a");
    step(100, 100, 'h0FF, 50,  1, 0, 1, "t2b");
    step(100, 100, 'h200, 201, 1, 1, 1, "t2c");
    chk_val("t2_cnt", 32'(count_out), 32'd0);
    chk_val("t2_vld", 32'(valid_out), 32'd1);
    step(0, 0, 0, 0, 0, 0, 1, "t2_idle");

    step(5, 6, 'h300, 20, 1, 1, 0, "rep_a");
    step(9, 4, 'h300, 21, 1, 1, 1, "rep_b");
    chk_val("rep_x",   32'(x_out), 32'd9);
    chk_val("rep_vld", 32'(valid_out), 32'd1);
    chk_val("rep_ovf", 32'(overflow_out), 32'd0);
    for (int i = 0; i < 16; i++) step(rnd16(), rnd16(), 'h200, 8 + i, 1, 1, 1, "b2b");
    step(0, 0, 0, 0, 0, 0, 1, "b2b_idle");

    step(3, 1, 'h200, 30, 1, 1, 0, "ovf_a");
    step(0, 0, 0,     0,  0, 0, 0, "ovf_bub");
    step(7, 2, 'h200, 31, 1, 1, 0, "ovf_b");
    chk_val("ovf_x",    32'(x_out), 32'd3);
    chk_val("ovf_flag", 32'(overflow_out), 32'd1);
    step(0, 0, 0, 0, 0, 0, 1, "ovf_rel");
    chk_val("ovf_drop", 32'(valid_out), 32'd0);

    for (int i = 0; i < 1024; i++) step(32767, 1, 'h200, 8 + (i % 193), 1, i == 1023, 1, "satp");
    chk_val("satp_x",   32'(x_out), 32'h7FFFF);
    chk_val("satp_cnt", 32'(count_out), 32'd1024);
    for (int i = 0; i < 1024; i++) step(-32768, -1, 'h200, 200 - (i % 193), 1, i == 1023, 1, "satn");
    chk_val("satn_x", 32'(x_out), 32'h80000);
    for (int i = 0; i < 2100; i++) step(0, 0, 'h100, 100, 1, i == 2099, 1, "csat");
    chk_val("csat_cnt", 32'(count_out), 32'd2047);

    for (int f = 0; f < 40; f++) begin
      int len;
      len = int'($urandom_range(1, 12));
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0)
          step(rnd16(), rnd16(), int'($urandom_range(0, 'h3FF)), int'($urandom_range(0, 255)),
               0, 1'($urandom), 1'($urandom), "rnd_bub");
        step(rnd16(), rnd16(), int'($urandom_range(0, 'h3FF)), int'($urandom_range(0, 255)),
             1, k == len - 1, 1'($urandom), "rnd");
      end
    end

    do_reset();
    for (int i = 0; i < 5; i++) step(40, -20, 'h200, 50 + i, 1, 0, 1, "mid");
    rst_in = 1'b1;
    #1;
    model_clear_all();
    check_outputs("mid_rst");
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    step(11, 12, 'h200, 60, 1, 0, 1, "post_a");
    step(13, 14, 'h200, 61, 1, 1, 1, "post_b");
    chk_val("post_cnt", 32'(count_out), 32'd2);
    chk_val("post_x",   32'(x_out), 32'd24);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/direction_accumulator.md
# direction_accumulator

Frame-level integrator sitting directly downstream of the per-bin direction calculator. It consumes one direction vector per FFT bin, keeps only bins inside a configured frequency band whose central-mic magnitude clears a threshold, and sums x and y across the frame with saturation. At end of frame it presents the summed vector and the contributing-bin count through a valid/ready output register, ready for the angle/display stage.

## Interface
- BIN_WIDTH, 10: width of the FFT bin index.
- BIN_LO, 8: lowest bin accumulated (inclusive).
- BIN_HI, 200: highest bin accumulated (inclusive).
- MAG_THRESHOLD, 16'h0100: minimum central magnitude (unsigned 3.13) for a bin to count.
- ACC_WIDTH, 26: accumulator width (signed, 9 fractional bits).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-high.
- vector_in  input  38  direction vector: [15:0] x, [31:16] y, each signed 7.9; [37:32] ignored.
- mag_in  input  16  central-mic magnitude for the same bin, unsigned 3.13.
- bin_in  input  BIN_WIDTH  bin index of the current sample.
- valid_in  input  1  sample present this cycle (no backpressure; always accepted).
- last_in  input  1  qualifies valid_in; final bin of the frame.
- x_out  output  ACC_WIDTH  summed x, signed.
- y_out  output  ACC_WIDTH  summed y, signed.
- count_out  output  BIN_WIDTH+1  number of bins summed.
- valid_out  output  1  result held.
- ready_in  input  1  consumer accepts result when valid_out && ready_in.
- overflow_out  output  1  sticky: a completed frame was dropped.

## Operation
- Sample qualifies when valid_in && BIN_LO <= bin_in <= BIN_HI && mag_in >= MAG_THRESHOLD (unsigned compare).
- Qualified sample: acc_x += sign-extended x, acc_y += sign-extended y, acc_cnt += 1.
- Adds saturate to ACC_WIDTH signed range: max 2^(ACC_WIDTH-1)-1, min -2^(ACC_WIDTH-1); no wrap. Saturated value stays until frame end.
- acc_cnt saturates at all-ones.
- valid_in && last_in ends the frame regardless of qualification; the last sample is included if it qualifies. Final sums (including that sample) form the frame result; accumulators clear to 0 the same edge.
- Frame with zero qualifying bins still produces a result: x=y=0, count=0.
- Output register, two states:
  - EMPTY (valid_out=0): frame result loads, go FULL.
  - FULL (valid_out=1): outputs held stable. ready_in=1 with no new result -> EMPTY. New result with ready_in=1 -> load new result, stay FULL. New result with ready_in=0 -> new result discarded, overflow_out set, stay FULL.
- Accumulation never stalls; the next frame begins the cycle after last_in.
- overflow_out cleared only by rst_in.

## Timing
- Reset (async assert, applies immediately): x_out=0, y_out=0, count_out=0, valid_out=0, overflow_out=0, accumulators 0, state EMPTY. Removal synchronous to clk_in.
- Sample at edge N contributes to internal accumulators visible after N.
- last_in at edge N: valid_out=1 and result on outputs after edge N (1-cycle latency); accumulators 0 after N.
- Handshake completes on edge where valid_out && ready_in; valid_out low after that edge unless a new result loads on the same edge.
- valid_in=0 cycles: no change (bubbles allowed anywhere in the frame).
- Back-to-back single-sample frames (last_in every cycle) sustained at one result per cycle while ready_in=1.

## Test plan
- Reset then 3 in-band bins, mag 0x0200, vectors (x,y)=(0x0200,0x0100),(0xFE00,0x0100),(0x0080,0xFF00) with last on 3rd, ready_in=1 -> one cycle later x_out=0x080, y_out=0x100, count_out=3, valid_out for 1 cycle.
- Bins 7, 201 and a bin with mag 0x00FF, last on bin 201 -> result x=y=0, count_out=0, valid_out=1.
- 1024 in-band bins of x=0x7FFF with ACC_WIDTH=20 -> x_out=0x7FFFF (saturated), count=1024; repeat with 0x8000 -> 0x80000.
- Frame done, ready_in=0 held; second frame completes -> first result still on outputs, overflow_out=1; raise ready_in -> valid_out drops next edge.
- ready_in=1 on the same edge a new frame completes while FULL -> new result loaded, valid_out stays 1, overflow_out stays 0.
- Assert rst_in mid-frame after 5 qualifying bins -> outputs 0 immediately; next frame of 2 bins reports count_out=2.
